// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS core's hazard logic:
// register index width, NOP encoding, shadow-entry layout and stage count.
package cpu_pkg;

   localparam int          REG_W         = 5;
   localparam logic [31:0] NOP_INST      = 32'h0000_0000;
   localparam int          SHADOW_STAGES = 3;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] dst;
   } shadowEntry_t;

endpackage

// File: rtl/haz_shadow_stage.sv
// One shadow-pipeline slot {v, reg} with async active-low clear and two
// compare ports (rs and rt lookups from the ID stage).
module haz_shadow_stage import cpu_pkg::*; #(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dV,
   input  logic [REG_W-1:0] dReg,
   input  logic [REG_W-1:0] cmpA,
   input  logic [REG_W-1:0] cmpB,
   output logic             qV,
   output logic [REG_W-1:0] qReg,
   output logic             hitA,
   output logic             hitB
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qV   <= 1'b0;
         qReg <= '0;
      end else begin
         qV   <= dV;
         qReg <= dReg;
      end
   end

   assign hitA = qV & (qReg == cmpA);
   assign hitB = qV & (qReg == cmpB);

endmodule

// File: rtl/hazard_sched.sv
// RAW stall / redirect flush control for the forwarding-less 5-stage core.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module hazard_sched import cpu_pkg::*; #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wr_en,
   input  logic [REG_W-1:0] id_wr_reg,
   input  logic             id_redirect,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_exe_bubble,
   output logic             busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   // Index 0 = EXE, 1 = MEM, 2 = WB.
   logic [SHADOW_STAGES-1:0] stV;
   logic [SHADOW_STAGES-1:0] hitRs;
   logic [SHADOW_STAGES-1:0] hitRt;
   logic [SHADOW_STAGES-1:0] dV;
   logic [REG_W-1:0]         stReg [SHADOW_STAGES];
   logic [REG_W-1:0]         dReg  [SHADOW_STAGES];
   logic                     matchRs;
   logic                     matchRt;
   logic                     hz;
   logic                     exeLoad;

   for (genvar i = 0; i < SHADOW_STAGES; i++) begin : gStage
      haz_shadow_stage #(.REG_W(REG_W)) uStage (
         .clk  (clk),
         .rst  (rst),
         .dV   (dV[i]),
         .dReg (dReg[i]),
         .cmpA (id_rs),
         .cmpB (id_rt),
         .qV   (stV[i]),
         .qReg (stReg[i]),
         .hitA (hitRs[i]),
         .hitB (hitRt[i])
      );
   end

   assign dV = {stV[SHADOW_STAGES-2:0], exeLoad};

   always_comb begin
      dReg[0] = id_wr_reg;
      for (int i = 1; i < SHADOW_STAGES; i++) begin
         dReg[i] = stReg[i-1];
      end
   end

   // $0 is hardwired, so it can never be a real dependency.
   assign matchRs = (id_rs != '0) & (|hitRs);
   assign matchRt = (id_rt != '0) & (|hitRt);

   assign hz      = rst & id_valid & ((id_use_rs & matchRs) | (id_use_rt & matchRt));
   assign exeLoad = id_valid & id_wr_en & ~hz & (id_wr_reg != '0);

   assign pc_stall      = hz;
   assign if_id_stall   = hz;
   assign id_exe_bubble = hz;
   // A stalled jr/jalr may still be waiting on its target register, so the redirect is held off.
   assign if_id_flush   = rst & id_valid & id_redirect & ~hz;
   assign busy          = |stV;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
         if (if_id_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed-vector bench for hazard_sched: driver pushes hand-computed
// expected {stall, if_id_stall, bubble, flush, busy} per cycle; a monitor checks them.
module tb_hazard_sched;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic             id_use_rs = 1'b0;
   logic             id_use_rt = 1'b0;
   logic             id_wr_en = 1'b0;
   logic [REG_W-1:0] id_wr_reg = '0;
   logic             id_redirect = 1'b0;
   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_exe_bubble;
   logic             busy;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   hazard_sched #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_use_rs     (id_use_rs),
      .id_use_rt     (id_use_rt),
      .id_wr_en      (id_wr_en),
      .id_wr_reg     (id_wr_reg),
      .id_redirect   (id_redirect),
      .pc_stall      (pc_stall),
      .if_id_stall   (if_id_stall),
      .if_id_flush   (if_id_flush),
      .id_exe_bubble (id_exe_bubble),
      .busy          (busy)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   // Clock / reset block: reset is held low by the first driver vectors.
   always #5 clk = ~clk;

   int         compared   = 0;
   int         mismatched = 0;
   int         vecId      = 0;
   logic [4:0] exp_q[$];
   int         tag_q[$];
   logic [4:0] monExp;
   logic [4:0] monAct;
   int         monTag;

   // Scoreboard monitor: outputs are stable mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         monExp = exp_q.pop_front();
         monTag = tag_q.pop_front();
         monAct = {pc_stall, if_id_stall, id_exe_bubble, if_id_flush, busy};
         compared++;
         if (monAct !== monExp) begin
            mismatched++;
            $display("FAIL vec%0d {stall,ifIdStall,bubble,flush,busy}: got %b expected %b",
                     monTag, monAct, monExp);
         end
      end
   end

   task automatic step(input logic r, input logic v,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic ur, input logic ut, input logic we,
                       input logic [REG_W-1:0] wr, input logic rd,
                       input logic eStall, input logic eFlush, input logic eBusy);
      @(posedge clk);
      #1;
      rst         = r;
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_use_rs   = ur;
      id_use_rt   = ut;
      id_wr_en    = we;
      id_wr_reg   = wr;
      id_redirect = rd;
      exp_q.push_back({eStall, eStall, eStall, eFlush, eBusy});
      tag_q.push_back(vecId);
      vecId++;
   endtask

   task automatic idle(input logic eBusy);
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eBusy);
   endtask

   task automatic drain();
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
   endtask

   initial begin
      // Reset held: even a redirect or would-be hazard must produce all-zero outputs.
      step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);

      // addu $3,$1,$2 ; addu $4,$3,$0 -> 3 stall cycles (producer in EXE).
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // jal (-> $31) then jr $31: flush, 3 stalls with flush held off, then flush.
      step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b0);

`ifdef HAZ_PERF_CNT_EN
      @(negedge clk);
      compared++;
      if (stall_cnt !== 32'd6) begin
         mismatched++;
         $display("FAIL stall_cnt: got %0d expected 6", stall_cnt);
      end
      compared++;
      if (flush_cnt !== 32'd2) begin
         mismatched++;
         $display("FAIL flush_cnt: got %0d expected 2", flush_cnt);
      end
`endif

      // addu $0,$1,$2 ; addu $4,$0,$0 -> $0 is never entered nor hazards.
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // addu $5, two independents, reader of $5 -> 1 stall (producer in WB).
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      // rs on $6 and rt on $7 in different stages: stall until $7 (youngest) retires.
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // Back-to-back writes of $9, then a reader: youngest writer governs (3 stalls).
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);

      // Reset asserted in the 2nd cycle of a 3-cycle stall; reader then issues cleanly.
      step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      drain();

      // Let the monitor consume everything, bounded.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core (IF/ID/EXE/MEM/WB).
- The datapath has no forwarding. The register file is written at the clock edge that ends WB and is read combinationally in ID.
- This block tracks destination registers of in-flight instructions in a 3-entry shadow pipeline. It stalls PC and IF/ID on a RAW hazard, injects a bubble into ID/EXE, and flushes IF/ID on a taken ID-stage redirect (j/jal/jr/jalr/branch).
- Sits beside the ID stage. It drives the PC enable, the if_id enable/flush and the id_exe bubble controls.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction (not a bubble or flush slot).
- id_rs  in  REG_W  id_inst[25:21].
- id_rt  in  REG_W  id_inst[20:16].
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes the RF (the RegWrite decode).
- id_wr_reg  in  REG_W  final destination after RegDst/call muxing (31 for jal/jalr).
- id_redirect  in  1  NPCOp selects a non-sequential PC this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  load a NOP into IF/ID at the next edge.
- id_exe_bubble  out  1  load a NOP (all controls 0) into ID/EXE at the next edge.
- busy  out  1  any shadow entry valid.

Behaviour:
- Shadow entries: {v, reg} for EXE, MEM and WB.
- Every edge: WB<=MEM, MEM<=EXE.
- EXE loads {id_valid & id_wr_en & ~hz & (id_wr_reg!=0), id_wr_reg}. When hz=1 it loads {0,x}.
- match(r) = (r!=0) & OR over stages of (v & reg==r).
- hz = id_valid & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt))). This is combinational, same cycle.
- pc_stall = if_id_stall = id_exe_bubble = hz.
- if_id_flush = id_valid & id_redirect & ~hz. A redirect is not accepted while stalled, so jr and jalr wait for rs.
- If hz and a redirect coincide, hz wins; the redirect is re-evaluated next cycle.
- The flush itself does not create a shadow entry. The redirecting instruction's own write (jal to $31) is entered normally.
- Latency:
  - Dependent instruction in ID with producer in EXE: stall 3 cycles.
  - Producer in MEM: stall 2 cycles.
  - Producer in WB: stall 1 cycle.
- Register $0 never hazards and is never entered.
- Both operands hazarding on different stages: the stall lasts until the youngest producer retires.
- Back-to-back writes to the same register: matching any entry stalls, so the youngest governs.
- Reset (rst=0, any time, including mid-stall): all v<=0 immediately. Outputs are forced to 0 while rst=0. After release there are no stale stalls.
- busy = OR of v bits (registered state only).
- Reset values: pc_stall=0, if_id_stall=0, if_id_flush=0, id_exe_bubble=0, busy=0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
- Each counter increments once per cycle in which pc_stall or if_id_flush, respectively, is 1.
- Both saturate at all-ones and clear to 0 on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg: REG_W, the NOP encoding 32'h0000_0000, the shadow-entry struct {v, reg}, and the stage-count constant 3.
- One natural sub-module: haz_shadow_stage, a single {v, reg} register with async active-low clear and compare output. It is instantiated 3 times, chained EXE to MEM to WB.

Test Plan:
- addu $3,$1,$2 followed by addu $4,$3,$0: pc_stall=1 for exactly 3 cycles, id_exe_bubble=1 for the same 3 cycles, then issue. $4 is correct after WB.
- addu $0,$1,$2 followed by addu $4,$0,$0: no stall cycles; busy stays 0.
- addu $5 then two independent instructions, then a reader of $5: the reader sees 1 stall cycle (producer in WB).
- jal at PC 0x10 followed immediately by jr $31: jal gives if_id_flush=1 for 1 cycle; jr stalls 3 cycles on $31, then if_id_flush=1 for 1 cycle, with no flush during the stall.
- rst pulled low during the 2nd cycle of a 3-cycle stall: all outputs are 0 at once and busy=0. After release, the same reader issues without a stall.
- HAZ_PERF_CNT_EN defined, with scenarios 1 and 4 run in sequence: stall_cnt=6 and flush_cnt=2.
